data_mem_lsu: RTL

//  Load/store initiator in front of the word-wide data RAM (sync write, registered read address, no byte enables).

---
 rtl/data_mem_lsu.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// Purpose: byte-addressed load/store unit in front of a word-wide data RAM without byte enables.
// Latency: SW and errors respond 1 cycle after accept; loads, SB and SH respond 2 cycles after accept.
// Backpressure: req_ready is high only in IDLE; resp_valid is a single-cycle pulse with no backpressure.
module data_mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, LD_DATA, ST_MERGE} state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_off;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_resp_valid, r_resp_err;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [1:0]              w_off;
  logic                    w_fire, w_legal, w_misal, w_err, w_is_sw;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load, w_merge;
  logic                    w_unused_addr;

  // Address bits above the RAM depth wrap, so they are intentionally ignored.
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign w_idx     = req_addr[ADDR_WIDTH+1:2];
  assign w_off     = req_addr[1:0];
  assign req_ready = (r_state == IDLE) && rst_n;
  assign w_fire    = req_valid && req_ready;
  assign w_is_sw   = req_we && (req_funct3 == 3'b010);

  // Decode legality and alignment of the incoming request.
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    if (req_we) begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    if (req_funct3[1:0] == 2'b01) w_misal = w_off[0];
    if (req_funct3[1:0] == 2'b10) w_misal = (w_off != 2'b00);
    w_err = !w_legal || w_misal;
  end

  // Extract and extend the addressed byte/half from the word the RAM returned.
  always_comb begin
    w_byte = mem_data_out[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = mem_data_out;
    endcase
  end

  // Splice the store byte/half into the old word so untouched bytes survive the RMW.
  always_comb begin
    w_merge = mem_data_out;
    if (r_funct3 == 3'b000) w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else                    w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // Next-state and RAM port control; all RAM writes are gated by reset.
  always_comb begin
    w_next      = r_state;
    mem_addr    = w_idx;
    mem_data_in = req_wdata;
    mem_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire && !w_err) begin
          if (w_is_sw)     mem_we = rst_n;
          else if (req_we) w_next = ST_MERGE;
          else             w_next = LD_DATA;
        end
      end
      LD_DATA: w_next = IDLE;
      ST_MERGE: begin
        mem_addr    = r_addr;
        mem_data_in = w_merge;
        mem_we      = rst_n;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, request latches and the registered response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_off        <= 2'b00;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      if (w_fire) begin
        r_off    <= w_off;
        r_funct3 <= req_funct3;
        r_addr   <= w_idx;
        r_wdata  <= req_wdata;
        if (w_err) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end else if (w_is_sw) begin
          r_resp_valid <= 1'b1;
        end
      end
      if (r_state == LD_DATA) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= w_load;
      end
      if (r_state == ST_MERGE) r_resp_valid <= 1'b1;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule
